// File: rtl/perf_counter_bank.sv
// ----------------------------------------------------------------------------
// perf_counter_bank
//
// Bank of NumCh event counters used for core performance statistics
// (cycles, jumps, branches, bubbles, load-use stalls, BHT hit/fail, ...).
//
// Features:
//   - per-channel increment on level-sampled event strobes, gated by en
//   - global synchronous clear of live counters and overflow flags
//   - atomic snapshot of every live counter into a shadow set
//   - wrap (Saturate=0) or saturate (Saturate=1) on overflow, with a
//     sticky per-channel overflow flag
//   - registered readout mux, manually selected or auto-scanned (for the
//     7-segment display), with cur_ch always naming the channel in rd_data
//
// Ports:
//   clk       in   1        clock, all state updates on the rising edge
//   rst_n     in   1        synchronous reset, active low, overrides all
//   en        in   1        global count enable
//   evt       in   NumCh    per-channel event strobes
//   clr       in   1        clear live counters and overflow flags
//   snap      in   1        copy live counters into the shadow set
//   use_snap  in   1        readout source: 1 = shadow, 0 = live
//   scan_en   in   1        1 = auto-rotate channel, 0 = channel follows sel
//   sel       in   SelBit   manual channel select
//   cur_ch    out  SelBit   channel currently driving rd_data
//   rd_data   out  CntBit   registered value of channel cur_ch
//   ovf       out  NumCh    sticky overflow flags
//
// All outputs come straight from registers; there is no combinational
// path from any input to any output.
// ----------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int NumCh    = 8,
    parameter int CntBit   = 32,
    parameter int SelBit   = 3,
    parameter int Saturate = 0,
    parameter int DwellCnt = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NumCh-1:0]  evt,
    input  logic              clr,
    input  logic              snap,
    input  logic              use_snap,
    input  logic              scan_en,
    input  logic [SelBit-1:0] sel,
    output logic [SelBit-1:0] cur_ch,
    output logic [CntBit-1:0] rd_data,
    output logic [NumCh-1:0]  ovf
);

    // Dwell counter must hold 0..DwellCnt-1; keep at least one bit so a
    // DwellCnt of 1 (advance every cycle) still elaborates cleanly.
    localparam int              DwW     = (DwellCnt > 1) ? $clog2(DwellCnt) : 1;
    localparam logic [DwW-1:0]  DwLast  = DwW'(DwellCnt - 1);
    localparam logic [CntBit-1:0] CntMax = {CntBit{1'b1}};
    localparam logic [SelBit-1:0] LastCh = SelBit'(NumCh - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CntBit-1:0] r_live   [NumCh];
    logic [CntBit-1:0] r_shadow [NumCh];
    logic [NumCh-1:0]  r_ovf;
    logic [DwW-1:0]    r_dwell;
    logic [SelBit-1:0] r_cur_ch;
    logic [CntBit-1:0] r_rd_data;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic [NumCh-1:0]  w_inc;
    logic [NumCh-1:0]  w_at_max;
    logic [DwW-1:0]    w_next_dwell;
    logic [SelBit-1:0] w_next_ch;
    logic [CntBit-1:0] w_rd_next;

    // A clear wins over a same-cycle increment, so it masks the increment.
    assign w_inc = (en && !clr) ? evt : '0;

    always_comb begin
        w_at_max = '0;
        for (int i = 0; i < NumCh; i++) begin
            w_at_max[i] = (r_live[i] == CntMax);
        end
    end

    // Channel selection. Leaving scan mode snaps back to sel with the dwell
    // counter parked at 0, so re-entering scan mode starts from whatever
    // channel is showing with a full dwell period ahead of it.
    always_comb begin
        w_next_ch    = r_cur_ch;
        w_next_dwell = r_dwell;
        if (!scan_en) begin
            w_next_ch    = sel;
            w_next_dwell = '0;
        end else if (r_dwell == DwLast) begin
            w_next_dwell = '0;
            w_next_ch    = (r_cur_ch == LastCh) ? '0 : r_cur_ch + SelBit'(1);
        end else begin
            w_next_dwell = r_dwell + DwW'(1);
        end
    end

    // Readout mux keyed on the channel cur_ch takes at this same edge, so
    // the pair (cur_ch, rd_data) is always self-consistent. The values read
    // are the pre-edge register contents, hence live readout lags the
    // counter by one cycle. Channels beyond NumCh read as zero.
    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (w_next_ch == SelBit'(i)) begin
                w_rd_next = use_snap ? r_shadow[i] : r_live[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Live counters and sticky overflow flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                r_live[i] <= '0;
            end
            r_ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < NumCh; i++) begin
                r_live[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (w_inc[i]) begin
                    if (w_at_max[i]) begin
                        r_ovf[i]  <= 1'b1;
                        r_live[i] <= (Saturate != 0) ? CntMax : '0;
                    end else begin
                        r_live[i] <= r_live[i] + CntBit'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow set: captures the pre-edge live values, so a snap coinciding
    // with clr or an increment still records the value before that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NumCh; i++) begin
                r_shadow[i] <= r_live[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel select, dwell counter and registered readout
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_cur_ch  <= '0;
            r_rd_data <= '0;
        end else begin
            r_dwell   <= w_next_dwell;
            r_cur_ch  <= w_next_ch;
            r_rd_data <= w_rd_next;
        end
    end

    assign cur_ch  = r_cur_ch;
    assign rd_data = r_rd_data;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// ----------------------------------------------------------------------------
// tb_perf_counter_bank
//
// Three differently configured instances share one set of stimulus:
//   dut0: NumCh=8, CntBit=4, wrap,     DwellCnt=3
//   dut1: NumCh=3, CntBit=4, saturate, DwellCnt=3
//   dut2: NumCh=6, CntBit=8, wrap,     DwellCnt=2
// A behavioural model predicts every output of every instance after each
// edge; predictions go into exp_q and are popped when the outputs are
// sampled one time unit after the edge. Directed sequences add explicit
// checks against hand-derived constants.
// ----------------------------------------------------------------------------
module tb_perf_counter_bank;

    // ------------------------------------------------------------------
    // Clock / reset and stimulus signals
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic [7:0] evt;
    logic       clr;
    logic       snap;
    logic       use_snap;
    logic       scan_en;
    logic [2:0] sel;

    logic [2:0] cur0, cur1, cur2;
    logic [3:0] rd0;
    logic [3:0] rd1;
    logic [7:0] rd2;
    logic [7:0] ovf0;
    logic [2:0] ovf1;
    logic [5:0] ovf2;

    perf_counter_bank #(.NumCh(8), .CntBit(4), .SelBit(3), .Saturate(0), .DwellCnt(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt[7:0]), .clr(clr), .snap(snap),
        .use_snap(use_snap), .scan_en(scan_en), .sel(sel),
        .cur_ch(cur0), .rd_data(rd0), .ovf(ovf0)
    );

    perf_counter_bank #(.NumCh(3), .CntBit(4), .SelBit(3), .Saturate(1), .DwellCnt(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt[2:0]), .clr(clr), .snap(snap),
        .use_snap(use_snap), .scan_en(scan_en), .sel(sel),
        .cur_ch(cur1), .rd_data(rd1), .ovf(ovf1)
    );

    perf_counter_bank #(.NumCh(6), .CntBit(8), .SelBit(3), .Saturate(0), .DwellCnt(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt[5:0]), .clr(clr), .snap(snap),
        .use_snap(use_snap), .scan_en(scan_en), .sel(sel),
        .cur_ch(cur2), .rd_data(rd2), .ovf(ovf2)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        check(tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts as plain integers per configuration
    // ------------------------------------------------------------------
    int cfg_nch   [3] = '{8, 3, 6};
    int cfg_bits  [3] = '{4, 4, 8};
    int cfg_sat   [3] = '{0, 1, 0};
    int cfg_dwell [3] = '{3, 3, 2};

    int m_live   [3][8];
    int m_shadow [3][8];
    int m_ovf    [3][8];
    int m_cur    [3];
    int m_dw     [3];
    int m_rd     [3];

    task automatic model_edge();
        int cmax;
        int old_live [8];
        int old_shadow [8];
        int ovf_bits;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    m_live[d][i] = 0; m_shadow[d][i] = 0; m_ovf[d][i] = 0;
                end
                m_cur[d] = 0; m_dw[d] = 0; m_rd[d] = 0;
            end else begin
                cmax = (1 << cfg_bits[d]) - 1;
                for (int i = 0; i < 8; i++) begin
                    old_live[i]   = m_live[d][i];
                    old_shadow[i] = m_shadow[d][i];
                end
                // channel shown after this edge
                if (!scan_en) begin
                    m_cur[d] = sel; m_dw[d] = 0;
                end else if (m_dw[d] == cfg_dwell[d] - 1) begin
                    m_dw[d]  = 0;
                    m_cur[d] = (m_cur[d] == cfg_nch[d] - 1) ? 0 : (m_cur[d] + 1) % 8;
                end else begin
                    m_dw[d] = m_dw[d] + 1;
                end
                if (m_cur[d] < cfg_nch[d])
                    m_rd[d] = use_snap ? old_shadow[m_cur[d]] : old_live[m_cur[d]];
                else
                    m_rd[d] = 0;
                if (snap)
                    for (int i = 0; i < 8; i++) m_shadow[d][i] = old_live[i];
                for (int i = 0; i < cfg_nch[d]; i++) begin
                    if (clr) begin
                        m_live[d][i] = 0; m_ovf[d][i] = 0;
                    end else if (en && evt[i]) begin
                        if (m_live[d][i] == cmax) begin
                            m_ovf[d][i]  = 1;
                            m_live[d][i] = (cfg_sat[d] != 0) ? cmax : 0;
                        end else begin
                            m_live[d][i] = m_live[d][i] + 1;
                        end
                    end
                end
            end
            ovf_bits = 0;
            for (int i = 0; i < 8; i++) if (m_ovf[d][i] != 0) ovf_bits = ovf_bits | (1 << i);
            exp_q.push_back(32'(m_cur[d]));
            exp_q.push_back(32'(m_rd[d]));
            exp_q.push_back(32'(ovf_bits));
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock edge, model update, sample one unit later
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_q("cur0", 32'(cur0)); check_q("rd0", 32'(rd0)); check_q("ovf0", 32'(ovf0));
        check_q("cur1", 32'(cur1)); check_q("rd1", 32'(rd1)); check_q("ovf1", 32'(ovf1));
        check_q("cur2", 32'(cur2)); check_q("rd2", 32'(rd2)); check_q("ovf2", 32'(ovf2));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; en = 1'b1; evt = 8'hFF; clr = 1'b0; snap = 1'b0;
        use_snap = 1'b0; scan_en = 1'b0; sel = 3'd0;

        // reset dominates running events
        steps(2);
        check("t1_rst_rd0", 32'(rd0), 32'h0);
        check("t1_rst_ovf0", 32'(ovf0), 32'h0);
        check("t1_rst_cur0", 32'(cur0), 32'h0);

        // five events on ch0, read one cycle after the last edge
        rst_n = 1'b1; evt = 8'h01;
        steps(5);
        evt = 8'h00;
        step();
        check("t1_ch0_five", 32'(rd0), 32'd5);
        sel = 3'd1;
        step();
        check("t1_ch1_zero", 32'(rd0), 32'd0);

        // no enable: counters hold
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b0; evt = 8'hFF; sel = 3'd0;
        steps(10);
        check("t2_hold_rd0", 32'(rd0), 32'd0);
        check("t2_hold_ovf0", 32'(ovf0), 32'd0);
        check("t2_hold_rd2", 32'(rd2), 32'd0);

        // 17 events on ch2: wrap vs saturate
        en = 1'b1; evt = 8'h04;
        steps(17);
        evt = 8'h00; sel = 3'd2;
        step();
        check("t3_wrap_rd", 32'(rd0), 32'd1);
        check("t3_wrap_ovf", 32'(ovf0), 32'h04);
        check("t3_sat_rd", 32'(rd1), 32'hF);
        check("t3_sat_ovf", 32'(ovf1), 32'h4);
        check("t3_wide_rd", 32'(rd2), 32'd17);
        clr = 1'b1; step(); clr = 1'b0;
        check("t3_clr_ovf0", 32'(ovf0), 32'd0);
        check("t3_clr_ovf1", 32'(ovf1), 32'd0);
        step();
        check("t3_clr_rd0", 32'(rd0), 32'd0);
        check("t3_clr_rd1", 32'(rd1), 32'd0);

        // snap and clr on the same edge as an increment
        sel = 3'd0; evt = 8'h01;
        steps(7);
        snap = 1'b1; clr = 1'b1;
        step();
        snap = 1'b0; clr = 1'b0; evt = 8'h00; use_snap = 1'b1;
        step();
        check("t4_shadow0", 32'(rd0), 32'd7);
        check("t4_shadow1", 32'(rd1), 32'd7);
        check("t4_shadow2", 32'(rd2), 32'd7);
        use_snap = 1'b0;
        step();
        check("t4_live0", 32'(rd0), 32'd0);

        // auto-scan on the 3-channel instance, dwell 3
        scan_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("t5_scan_k%0d", k), 32'(cur1), 32'((k / 3) % 3));
        end
        scan_en = 1'b0; sel = 3'd2;
        step();
        check("t5_scan_exit", 32'(cur1), 32'd2);

        // out-of-range select and reset during scan
        sel = 3'd7;
        step();
        check("t6_oor_cur2", 32'(cur2), 32'd7);
        check("t6_oor_rd2", 32'(rd2), 32'd0);
        check("t6_oor_rd1", 32'(rd1), 32'd0);
        scan_en = 1'b1;
        steps(4);
        rst_n = 1'b0;
        step();
        check("t6_rst_cur2", 32'(cur2), 32'd0);
        check("t6_rst_rd2", 32'(rd2), 32'd0);
        check("t6_rst_cur0", 32'(cur0), 32'd0);
        rst_n = 1'b1; scan_en = 1'b0;

        // randomized traffic; clears become rare in the second half so the
        // wider counters get a chance to overflow too
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            en    = ($urandom_range(0, 9) != 0);
            evt   = 8'($urandom);
            clr   = (k < 1500) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 999) == 0);
            snap  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) use_snap = ~use_snap;
            if ($urandom_range(0, 29) == 0) scan_en = ~scan_en;
            if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
